// File: rtl/riscv_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, data-memory wait
// freezing with a bus timeout that latches a sticky error until reset.
module riscv_hazard_ctrl #(
  parameter int DMEM_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic        i_id_use_rs1,
  input  logic        i_id_use_rs2,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_is_load,
  input  logic        i_ex_br_taken,
  input  logic        i_mem_req,
  input  logic        i_mem_ack,
  output logic        o_en_pc,
  output logic        o_en_ifid,
  output logic        o_en_idex,
  output logic        o_en_exmem,
  output logic        o_en_memwb,
  output logic        o_flush_ifid,
  output logic        o_flush_idex,
  output logic        o_bus_err,
  output logic [31:0] o_stall_cnt
);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_t;

  state_t      r_state;
  logic [7:0]  r_tcnt;
  logic        r_bus_err;
  logic [31:0] r_stall_cnt;

  logic w_mem_stall;
  logic w_load_use;

  assign w_mem_stall = i_mem_req & ~i_mem_ack;
  assign w_load_use  = i_ex_is_load & (i_ex_rd != 5'd0) &
                       ((i_id_use_rs1 & (i_id_rs1 == i_ex_rd)) |
                        (i_id_use_rs2 & (i_id_rs2 == i_ex_rd)));

  // Outputs stay low during reset and in ERR; a memory stall freezes everything,
  // and a taken branch outranks a load-use bubble since the ID instruction dies.
  always_comb begin
    o_en_pc      = 1'b0;
    o_en_ifid    = 1'b0;
    o_en_idex    = 1'b0;
    o_en_exmem   = 1'b0;
    o_en_memwb   = 1'b0;
    o_flush_ifid = 1'b0;
    o_flush_idex = 1'b0;
    if (i_rstn && r_state != S_ERR && !w_mem_stall) begin
      o_en_idex  = 1'b1;
      o_en_exmem = 1'b1;
      o_en_memwb = 1'b1;
      if (i_ex_br_taken) begin
        o_en_pc      = 1'b1;
        o_en_ifid    = 1'b1;
        o_flush_ifid = 1'b1;
        o_flush_idex = 1'b1;
      end else if (w_load_use) begin
        o_flush_idex = 1'b1;
      end else begin
        o_en_pc   = 1'b1;
        o_en_ifid = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state   <= S_RUN;
      r_tcnt    <= 8'd0;
      r_bus_err <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_mem_stall) begin
            r_state <= S_WAIT;
            r_tcnt  <= 8'd1;
          end
        end
        S_WAIT: begin
          // Ack or a dropped request both release the wait; ack wins at timeout.
          if (!w_mem_stall) begin
            r_state <= S_RUN;
            r_tcnt  <= 8'd0;
          end else if (r_tcnt == 8'(DMEM_TIMEOUT)) begin
            r_state   <= S_ERR;
            r_bus_err <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
          end
        end
        default: r_state <= S_ERR;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)
      r_stall_cnt <= 32'd0;
    else if (r_state != S_ERR && !o_en_pc && r_stall_cnt != 32'hFFFF_FFFF)
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign o_bus_err   = r_bus_err;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Directed scoreboard bench for riscv_hazard_ctrl with a short bus timeout.
module tb_riscv_hazard_ctrl;
  localparam int TMO = 4;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic [4:0]  i_id_rs1 = '0, i_id_rs2 = '0, i_ex_rd = '0;
  logic        i_id_use_rs1 = 0, i_id_use_rs2 = 0, i_ex_is_load = 0, i_ex_br_taken = 0;
  logic        i_mem_req = 0, i_mem_ack = 0;
  logic        o_en_pc, o_en_ifid, o_en_idex, o_en_exmem, o_en_memwb;
  logic        o_flush_ifid, o_flush_idex, o_bus_err;
  logic [31:0] o_stall_cnt;

  riscv_hazard_ctrl #(.DMEM_TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
    .i_id_use_rs1(i_id_use_rs1), .i_id_use_rs2(i_id_use_rs2),
    .i_ex_rd(i_ex_rd), .i_ex_is_load(i_ex_is_load), .i_ex_br_taken(i_ex_br_taken),
    .i_mem_req(i_mem_req), .i_mem_ack(i_mem_ack),
    .o_en_pc(o_en_pc), .o_en_ifid(o_en_ifid), .o_en_idex(o_en_idex),
    .o_en_exmem(o_en_exmem), .o_en_memwb(o_en_memwb),
    .o_flush_ifid(o_flush_ifid), .o_flush_idex(o_flush_idex),
    .o_bus_err(o_bus_err), .o_stall_cnt(o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [4:0]  en;   // pc, ifid, idex, exmem, memwb
    logic [1:0]  fl;   // ifid, idex
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  logic chk = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   step_no = 0;

  // Monitor: samples in the low phase, 2 time units after stimulus changes.
  always @(negedge i_clk) begin
    #2;
    if (chk) begin
      exp_t e, a;
      a = '{en:  {o_en_pc, o_en_ifid, o_en_idex, o_en_exmem, o_en_memwb},
            fl:  {o_flush_ifid, o_flush_idex}, err: o_bus_err, cnt: o_stall_cnt};
      n_assert++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL step%0d: output seen with empty scoreboard", step_no);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL step%0d: got en=%b fl=%b err=%b cnt=%0d, expected en=%b fl=%b err=%b cnt=%0d",
                   step_no, a.en, a.fl, a.err, a.cnt, e.en, e.fl, e.err, e.cnt);
        end
      end
    end
  end

  task automatic step(input logic rstn, input logic ld, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                      input logic u2, input logic br, input logic req, input logic ack,
                      input logic [4:0] en, input logic [1:0] fl, input logic err,
                      input int cnt);
    @(negedge i_clk);
    i_rstn = rstn; i_ex_is_load = ld; i_ex_rd = rd;
    i_id_rs1 = rs1; i_id_use_rs1 = u1; i_id_rs2 = rs2; i_id_use_rs2 = u2;
    i_ex_br_taken = br; i_mem_req = req; i_mem_ack = ack;
    step_no++;
    exp_q.push_back('{en: en, fl: fl, err: err, cnt: 32'(cnt)});
    chk = 1'b1;
  endtask

  task automatic idle(input logic [4:0] en, input logic err, input int cnt);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, en, 2'b00, err, cnt);
  endtask

  task automatic mem(input logic req, input logic ack, input logic [4:0] en,
                     input logic err, input int cnt);
    step(1, 0, 0, 0, 0, 0, 0, 0, req, ack, en, 2'b00, err, cnt);
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 0, 0);  // held in reset
    idle(5'b11111, 0, 0);
    step(1, 1, 5, 5, 1, 0, 0, 0, 0, 0, 5'b00111, 2'b01, 0, 0);  // load-use rs1
    idle(5'b11111, 0, 1);
    step(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 5'b11111, 2'b00, 0, 1);  // x0 exempt
    step(1, 1, 7, 3, 1, 7, 1, 0, 0, 0, 5'b00111, 2'b01, 0, 1);  // load-use rs2
    step(1, 1, 3, 3, 0, 0, 0, 0, 0, 0, 5'b11111, 2'b00, 0, 2);  // rs1 match, unused
    step(1, 1, 5, 5, 1, 0, 0, 1, 0, 0, 5'b11111, 2'b11, 0, 2);  // branch over load-use
    // Memory wait: three stalled cycles then ack carrying a load-use bubble
    mem(1, 0, 5'b00000, 0, 2);
    mem(1, 0, 5'b00000, 0, 3);
    mem(1, 0, 5'b00000, 0, 4);
    step(1, 1, 5, 5, 1, 0, 0, 0, 1, 1, 5'b00111, 2'b01, 0, 5);
    idle(5'b11111, 0, 6);
    // Request dropped while waiting
    mem(1, 0, 5'b00000, 0, 6);
    mem(0, 0, 5'b11111, 0, 7);
    idle(5'b11111, 0, 7);
    // Ack on the last allowed wait cycle
    mem(1, 0, 5'b00000, 0, 7);
    for (int i = 0; i < TMO - 1; i++) mem(1, 0, 5'b00000, 0, 8 + i);
    mem(1, 1, 5'b11111, 0, 11);
    idle(5'b11111, 0, 11);
    // Timeout into ERR
    mem(1, 0, 5'b00000, 0, 11);
    for (int i = 0; i < TMO; i++) mem(1, 0, 5'b00000, 0, 12 + i);
    idle(5'b00000, 1, 16);
    step(1, 1, 5, 5, 1, 0, 0, 1, 0, 0, 5'b00000, 2'b00, 1, 16);
    mem(1, 1, 5'b00000, 1, 16);
    // Asynchronous reset from ERR, then normal operation
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b00000, 2'b00, 0, 0);
    idle(5'b11111, 0, 0);
    step(1, 1, 9, 0, 0, 9, 1, 0, 0, 0, 5'b00111, 2'b01, 0, 0);
    idle(5'b11111, 0, 1);
    @(negedge i_clk);
    chk = 1'b0;
    #5;
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "timeout");
  end
endmodule
